// File: rtl/uart_parity_even_tx.sv
// -----------------------------------------------------------------------------
// uart_parity_even_tx
//
// Serial transmitter for the even-parity UART frame consumed by the team's
// even-parity receiver. A parallel word is taken over a valid/ready handshake
// and sent as: start(0), DATA_BITS data bits LSB first, even parity, stop(1).
// The line idles high. Each serial bit is held for CLKS_PER_BIT clocks.
//
// Parameters
//   DATA_BITS     data bits per frame (1..8)
//   CLKS_PER_BIT  clocks per serial bit (>=1)
//
// Ports
//   clk         in   clock, rising edge
//   reset       in   synchronous, active-high reset
//   in_data     in   word to send, captured on handshake
//   in_valid    in   producer offers a word
//   in_ready    out  transmitter accepts a word this cycle
//   tx          out  registered serial line
//   busy        out  frame in progress (state other than IDLE)
//   frame_done  out  one-cycle pulse in the last clock of the stop bit
//
// Build option
//   UART_TX_HOLD_EN  when defined, a one-entry hold register lets a word be
//                    accepted while a frame is running, and the next frame
//                    follows the stop bit with no idle clock.
// -----------------------------------------------------------------------------
module uart_parity_even_tx #(
    parameter int DATA_BITS    = 4,
    parameter int CLKS_PER_BIT = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 tx,
    output logic                 busy,
    output logic                 frame_done
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam int BIT_W = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;
    logic                 done_q, done_d;
    logic                 accept;
    logic                 bit_end;

`ifdef UART_TX_HOLD_EN
    logic [DATA_BITS-1:0] hold_q, hold_d;
    logic                 hold_par_q, hold_par_d;
    logic                 hold_full_q, hold_full_d;

    assign in_ready = ~hold_full_q;
`else
    assign in_ready = (state_q == S_IDLE);
`endif

    assign accept  = in_valid & in_ready;
    assign bit_end = (cnt_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
`ifdef UART_TX_HOLD_EN
        hold_d      = hold_q;
        hold_par_d  = hold_par_q;
        hold_full_d = hold_full_q;
`endif

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                bit_d = '0;
                if (accept) begin
                    state_d = S_START;
                    shift_d = in_data;
                    par_d   = ^in_data;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    cnt_d   = '0;
                    bit_d   = '0;
                end
            end
            S_DATA: begin
                // The shifter always presents the current bit in position 0.
                if (bit_end) begin
                    cnt_d   = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q == BIT_LAST) begin
                        state_d = S_PARITY;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP;
                    cnt_d   = '0;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
`ifdef UART_TX_HOLD_EN
                    // Launch the parked word, or a word offered right now,
                    // without an idle clock in between.
                    if (hold_full_q) begin
                        state_d     = S_START;
                        shift_d     = hold_q;
                        par_d       = hold_par_q;
                        hold_full_d = 1'b0;
                    end else if (accept) begin
                        state_d = S_START;
                        shift_d = in_data;
                        par_d   = ^in_data;
                    end
`endif
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                bit_d   = '0;
            end
        endcase

`ifdef UART_TX_HOLD_EN
        // Words accepted mid-frame are parked; the final stop clock and IDLE
        // hand the word straight to the shifter instead.
        if (accept && (state_q != S_IDLE) && !((state_q == S_STOP) && bit_end)) begin
            hold_d      = in_data;
            hold_par_d  = ^in_data;
            hold_full_d = 1'b1;
        end
`endif

        // tx is decoded from the next state so the flop shows the new bit
        // in the same clock the state enters it.
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
            S_PARITY: tx_d = par_d;
            default:  tx_d = 1'b1;
        endcase

        done_d = (state_d == S_STOP) && (cnt_d == CNT_LAST);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
`ifdef UART_TX_HOLD_EN
            hold_full_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
`ifdef UART_TX_HOLD_EN
            hold_full_q <= hold_full_d;
`endif
        end
    end

    // Payload registers carry no reset; they are only observed after a capture.
    always_ff @(posedge clk) begin
        shift_q <= shift_d;
        par_q   <= par_d;
`ifdef UART_TX_HOLD_EN
        hold_q     <= hold_d;
        hold_par_q <= hold_par_d;
`endif
    end

    assign tx         = tx_q;
    assign busy       = (state_q != S_IDLE);
    assign frame_done = done_q;

endmodule

// File: tb/tb_uart_parity_even_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_parity_even_tx
//
// Two transmitters (CLKS_PER_BIT = 1 and 3) are driven independently. A driver
// issues directed and random words; on every handshake it pushes the word and
// its predicted first-tx clock into a queue. A monitor pops that queue when the
// frame is due and compares the line, busy and frame_done against a frame built
// from the word (start, data LSB first, even parity, stop).
// -----------------------------------------------------------------------------
module tb_uart_parity_even_tx;

    localparam int DB       = 4;
    localparam int RAND_END = 1200;
    localparam int BUDGET   = 20000;

    typedef struct {
        logic [DB-1:0] word;
        int            start;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input int cpb, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s (cpb=%0d) at %0t: got %0d, expected %0d", name, cpb, $time, act, exp);
        end
    endtask

    // Serial bit idx of the frame carrying word w.
    function automatic int frame_bit(input logic [DB-1:0] w, input int idx);
        if (idx == 0) return 0;
        if (idx <= DB) return int'(w[idx-1]);
        if (idx == DB + 1) return $countones(w) % 2;
        return 1;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : gen_dut
        localparam int CPB  = (g == 0) ? 1 : 3;
        localparam int FLEN = (DB + 3) * CPB;

        logic          reset    = 1'b1;
        logic [DB-1:0] in_data  = '0;
        logic          in_valid = 1'b0;
        logic          in_ready;
        logic          tx;
        logic          busy;
        logic          frame_done;
        logic          rst_at_edge;
        int            cyc = 0;
        bit            drv_done = 1'b0;
        exp_t          exp_q[$];

        uart_parity_even_tx #(
            .DATA_BITS   (DB),
            .CLKS_PER_BIT(CPB)
        ) u_dut (
            .clk       (clk),
            .reset     (reset),
            .in_data   (in_data),
            .in_valid  (in_valid),
            .in_ready  (in_ready),
            .tx        (tx),
            .busy      (busy),
            .frame_done(frame_done)
        );

        always @(posedge clk) begin
            cyc         <= cyc + 1;
            rst_at_edge <= reset;
        end

        initial begin : driver
            logic [DB-1:0] stim_q[$];
            int            phase;
            int            last_start;
            int            last_end;
            int            rst_cnt;
            bit            rst_armed;
            bit            exp_rdy;
            exp_t          e;
            phase      = 0;
            last_start = -1000;
            last_end   = -1000;
            rst_cnt    = 2;
            rst_armed  = 1'b0;
            forever begin
                @(negedge clk);
`ifdef UART_TX_HOLD_EN
                exp_rdy = !(last_start > cyc);
`else
                exp_rdy = (cyc > last_end);
`endif
                chk("in_ready", CPB, int'(in_ready), int'(exp_rdy));

                if (rst_cnt > 0) rst_cnt--;
                reset = (rst_cnt > 0);

                if (phase == 0 && rst_cnt == 0) begin
                    stim_q.push_back(4'b1011);
                    phase = 1;
                end else if (phase == 1 && stim_q.size() == 0 && cyc > last_end + 1) begin
                    stim_q.push_back(4'b0000);
                    stim_q.push_back(4'b0001);
                    phase = 2;
                end else if (phase == 2 && stim_q.size() == 0 && cyc > last_end + 1) begin
                    stim_q.push_back(4'h3);
                    stim_q.push_back(4'h5);
                    stim_q.push_back(4'h6);
                    phase = 3;
                end else if (phase == 3 && stim_q.size() == 0 && cyc > last_end + 1) begin
                    stim_q.push_back(4'h9);
                    rst_armed = 1'b1;
                    phase = 4;
                end else if (phase == 4 && !rst_armed && cyc > last_end + 1) begin
                    stim_q.push_back(4'hA);
                    phase = 5;
                end else if (phase == 5 && stim_q.size() == 0 && cyc > last_end + 1) begin
                    phase = 6;
                end else if (phase == 6 && cyc >= RAND_END) begin
                    phase = 7;
                end else if (phase == 7 && cyc > last_end + 2) begin
                    chk("frames_left", CPB, exp_q.size(), 0);
                    drv_done = 1'b1;
                    break;
                end

                if (phase == 6) begin
                    in_valid = ($urandom_range(0, 3) != 0);
                    in_data  = DB'($urandom);
                end else begin
                    in_valid = (stim_q.size() != 0);
                    in_data  = in_valid ? stim_q[0] : DB'($urandom);
                end

                // Reset at the fourth clock of the armed frame, or at random.
                if (rst_cnt == 0 &&
                    ((rst_armed && stim_q.size() == 0 && cyc == last_start + 3) ||
                     (phase == 6 && $urandom_range(0, 149) == 0))) begin
                    rst_armed = 1'b0;
                    rst_cnt   = 1;
                    reset     = 1'b1;
                    in_valid  = 1'b0;
                    while (exp_q.size() > 0 && exp_q[$].start > cyc) void'(exp_q.pop_back());
                    last_start = -1000;
                    last_end   = cyc;
                end

                if (!reset && in_valid && in_ready) begin
                    e.word  = in_data;
                    e.start = (cyc + 1 > last_end + 1) ? cyc + 1 : last_end + 1;
                    exp_q.push_back(e);
                    last_start = e.start;
                    last_end   = e.start + FLEN - 1;
                    if (phase < 6 && stim_q.size() > 0) void'(stim_q.pop_front());
                end
            end
        end

        initial begin : monitor
            exp_t cur;
            bit   in_frame;
            int   pos;
            in_frame = 1'b0;
            pos      = 0;
            forever begin
                @(negedge clk);
                if (rst_at_edge) begin
                    in_frame = 1'b0;
                    chk("reset_tx", CPB, int'(tx), 1);
                    chk("reset_busy", CPB, int'(busy), 0);
                    chk("reset_done", CPB, int'(frame_done), 0);
                end else begin
                    if (!in_frame && exp_q.size() > 0 && exp_q[0].start == cyc) begin
                        cur      = exp_q.pop_front();
                        in_frame = 1'b1;
                        pos      = 0;
                    end
                    if (in_frame) begin
                        chk("frame_tx", CPB, int'(tx), frame_bit(cur.word, pos / CPB));
                        chk("frame_busy", CPB, int'(busy), 1);
                        chk("frame_done", CPB, int'(frame_done), int'(pos == FLEN - 1));
                        pos++;
                        if (pos == FLEN) in_frame = 1'b0;
                    end else begin
                        chk("idle_tx", CPB, int'(tx), 1);
                        chk("idle_busy", CPB, int'(busy), 0);
                        chk("idle_done", CPB, int'(frame_done), 0);
                    end
                end
            end
        end
    end

    initial begin : finisher
        int waited;
        waited = 0;
        while (!(gen_dut[0].drv_done && gen_dut[1].drv_done) && waited < BUDGET) begin
            @(posedge clk);
            waited++;
        end
        chk("drivers_finished", 0, int'(gen_dut[0].drv_done && gen_dut[1].drv_done), 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
